// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : One-hot N-to-2^N decoder with static HOLD and dwell-timed
//               SCAN modes, gated by the enable E.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 E,
  input  logic [N-1:0]         A,
  input  logic                 load,
  input  logic                 mode,
  input  logic                 stop,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    Y,
  output logic [N-1:0]         idx,
  output logic                 wrap,
  output logic                 busy
);

  localparam int W = 1 << N;
  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [N-1:0]       r_idx, w_idx_nxt;
  logic [DWELL_W-1:0] r_dwell_reg, w_dwell_reg_nxt;
  logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
  logic               r_wrap, w_wrap_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_dwell_reg <= '0;
      r_dwell_cnt <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dwell_reg <= w_dwell_reg_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  // Load has priority over stop; scan only advances while enabled.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dwell_reg_nxt = r_dwell_reg;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_wrap_nxt      = 1'b0;
    if (load) begin
      w_idx_nxt       = A;
      w_dwell_reg_nxt = dwell;
      w_dwell_cnt_nxt = dwell;
      w_state_nxt     = mode ? ST_SCAN : ST_HOLD;
    end else if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_SCAN && E) begin
      if (r_dwell_cnt != '0) begin
        w_dwell_cnt_nxt = r_dwell_cnt - 1'b1;
      end else begin
        w_idx_nxt       = r_idx + 1'b1;
        w_dwell_cnt_nxt = r_dwell_reg;
        w_wrap_nxt      = &r_idx;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign Y    = (E && busy) ? (c_one << r_idx) : '0;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
`default_nettype wire
